// File: rtl/memory_m9k_acc_param.sv
// Dual-read, single-write word store with registered reads, a two-stage
// accumulate-write pipeline (mem += data) and a hardware zero-fill sweep that
// runs after reset and on CLEAR.
// Optional feature: define MEMORY_M9K_RD_BYPASS_EN to let reads see results
// still in flight in the write pipeline.
module memory_m9k_acc_param #(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              CLEAR,
  output logic              BUSY,
  input  logic              WR,
  input  logic              ACC,
  input  logic [ADDR_W-1:0] wr_address_word,
  input  logic [DATA_W-1:0] wr_data_word,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address_word_1,
  input  logic [ADDR_W-1:0] address_word_2,
  output logic [DATA_W-1:0] data_word_1,
  output logic [DATA_W-1:0] data_word_2,
  output logic              rd_valid
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  // One extra bit so DEPTH == 2**ADDR_W compares correctly.
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DepthLim);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q;
  logic [ADDR_W-1:0] sweep_addr_q;
  logic              busy_q;

  // S1 registers: op captured with the old value it will combine with.
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_acc_q;
  logic [DATA_W-1:0] s1_old_q;

  logic              wr_accept;
  logic [DATA_W-1:0] s2_result;
  logic [DATA_W-1:0] fwd_old;
  logic [DATA_W-1:0] rd_val_1;
  logic [DATA_W-1:0] rd_val_2;

  assign BUSY      = busy_q;
  assign wr_accept = WR && !busy_q;

  // S2 result for the op held in S1; written to the array at the next edge.
  always_comb begin
    s2_result = s1_data_q;
    if (s1_acc_q) s2_result = s1_old_q + s1_data_q;
  end

  // Old value for an op entering S1, forwarded from S2 on an address hit.
  always_comb begin
    fwd_old = '0;
    if (in_range(wr_address_word)) begin
      if (s1_valid_q && (s1_addr_q == wr_address_word)) fwd_old = s2_result;
      else fwd_old = mem[wr_address_word];
    end
  end

`ifdef MEMORY_M9K_RD_BYPASS_EN
  logic [DATA_W-1:0] s1_result;

  // Result of the op entering S1 this edge, using the forwarded old value.
  always_comb begin
    s1_result = wr_data_word;
    if (ACC) s1_result = fwd_old + wr_data_word;
  end

  // Read muxes: array, then S2 result, then the newer S1 result.
  always_comb begin
    rd_val_1 = '0;
    rd_val_2 = '0;
    if (in_range(address_word_1)) begin
      rd_val_1 = mem[address_word_1];
      if (s1_valid_q && (s1_addr_q == address_word_1)) rd_val_1 = s2_result;
      if (wr_accept && (wr_address_word == address_word_1)) rd_val_1 = s1_result;
    end
    if (in_range(address_word_2)) begin
      rd_val_2 = mem[address_word_2];
      if (s1_valid_q && (s1_addr_q == address_word_2)) rd_val_2 = s2_result;
      if (wr_accept && (wr_address_word == address_word_2)) rd_val_2 = s1_result;
    end
  end
`else
  // Read muxes: array only; out-of-range addresses read as zero.
  always_comb begin
    rd_val_1 = '0;
    rd_val_2 = '0;
    if (in_range(address_word_1)) rd_val_1 = mem[address_word_1];
    if (in_range(address_word_2)) rd_val_2 = mem[address_word_2];
  end
`endif

  // Sweep FSM: zero-fill one word per cycle, restartable by CLEAR.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StSweep;
      sweep_addr_q <= '0;
      busy_q       <= 1'b1;
    end else begin
      unique case (state_q)
        StSweep: begin
          if (CLEAR) begin
            sweep_addr_q <= '0;
          end else if (sweep_addr_q == LastAddr) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            sweep_addr_q <= '0;
          end else begin
            sweep_addr_q <= sweep_addr_q + 1'b1;
          end
        end
        StIdle: begin
          if (CLEAR) begin
            state_q      <= StSweep;
            busy_q       <= 1'b1;
            sweep_addr_q <= '0;
          end
        end
        default: begin
          state_q <= StSweep;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Write pipeline S1: capture accepted op and its (forwarded) old value.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_acc_q   <= 1'b0;
      s1_old_q   <= '0;
    end else begin
      s1_valid_q <= wr_accept;
      if (wr_accept) begin
        s1_addr_q <= wr_address_word;
        s1_data_q <= wr_data_word;
        s1_acc_q  <= ACC;
        s1_old_q  <= fwd_old;
      end
    end
  end

  // Array writes: S2 result, then sweep zero (sweep wins on a collision).
  always_ff @(posedge CLOCK_50) begin
    if (s1_valid_q && in_range(s1_addr_q)) mem[s1_addr_q] <= s2_result;
    if (state_q == StSweep) mem[sweep_addr_q] <= '0;
  end

  // Registered read ports; data holds when rd_en is low.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      data_word_1 <= '0;
      data_word_2 <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        data_word_1 <= rd_val_1;
        data_word_2 <= rd_val_2;
      end
    end
  end

endmodule
